// File: rtl/track_pkg.sv
// Shared types and helpers for the track tile RAM: tile/address widths and
// world-position to tile-address conversion.
package track_pkg;
   localparam int unsigned TILE_W       = 4;
   localparam int unsigned TRACK_ADDR_W = 8;
   localparam int unsigned TILE_SHIFT   = 7;

   typedef logic [TILE_W-1:0]       tile_t;
   typedef logic [TRACK_ADDR_W-1:0] track_addr_t;

   localparam logic [15:0] DEFAULT_SOLID_MASK = 16'h0001;

   // World units are 4x pixels and tiles are 32 pixels, so tile index = pos >> 7.
   function automatic track_addr_t pos_to_tile_addr(input logic [10:0] x, input logic [10:0] y);
      logic [10:0] tx;
      logic [10:0] ty;
      tx = x >> TILE_SHIFT;
      ty = y >> TILE_SHIFT;
      return {ty[3:0], tx[3:0]};
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority pointer moves past
// the granted requester so it becomes lowest priority next cycle.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] gidx;
   logic          found;
   int unsigned   idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      gidx  = ptr;
      idx   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr) + k) % N;
         if (!found && en && req[idx[PW-1:0]]) begin
            found                = 1'b1;
            gidx                 = idx[PW-1:0];
            gnt[idx[PW-1:0]]     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
      end
   end
endmodule

// File: rtl/track_map_arbiter.sv
// Shares the 2-cycle-latency track RAM read port between the pixel renderer
// (fixed slot per 32-pixel column) and round-robin collision requesters.
module track_map_arbiter
   import track_pkg::*;
#(
   parameter int          N_REQ      = 2,
   parameter logic [15:0] SOLID_MASK = DEFAULT_SOLID_MASK
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [10:0]        hcount_in,
   input  logic [9:0]         vcount_in,
   input  logic [N_REQ-1:0]   req_in,
   input  logic [N_REQ*11-1:0] req_x_in,
   input  logic [N_REQ*11-1:0] req_y_in,
   output logic [N_REQ-1:0]   gnt_out,
   output logic [N_REQ-1:0]   resp_valid_out,
   output logic [3:0]         resp_tile_out,
   output logic               resp_solid_out,
   output logic [7:0]         ram_addr_out,
   output logic               ram_en_out,
   input  logic [3:0]         ram_tile_in,
   output logic [3:0]         render_tile_out
);
   localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef struct packed {
      logic           valid;
      logic           is_render;
      logic [IDW-1:0] id;
   } tag_t;

   logic             first_cycle;
   logic             render_slot;
   logic [N_REQ-1:0] gnt;
   logic [IDW-1:0]   gnt_id;
   track_addr_t      req_addr;
   track_addr_t      addr_q;
   tag_t             tag1;
   tag_t             tag2;
   tile_t            render_hold;
   tile_t            resp_tile_q;
   logic             resp_now;
   logic             render_now;
   logic             unused_bits;

   assign unused_bits = ^{hcount_in[10:9], vcount_in[9]};

   assign render_slot = !rst_in && ((hcount_in[4:0] == '0) || first_cycle);

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk (clk_in),
      .rst (rst_in),
      .en  (!render_slot && !rst_in),
      .req (req_in),
      .gnt (gnt)
   );

   always_comb begin
      gnt_id   = '0;
      req_addr = addr_q;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            gnt_id   = IDW'(i);
            req_addr = pos_to_tile_addr(req_x_in[11*i +: 11], req_y_in[11*i +: 11]);
         end
      end
   end

   assign gnt_out      = gnt;
   assign ram_en_out   = render_slot || (|gnt);
   assign ram_addr_out = render_slot ? {vcount_in[8:5], hcount_in[8:5]} : req_addr;

   // Stage-2 tag lines up with ram_tile_in; reset suppresses anything still in flight.
   assign resp_now   = tag2.valid && !tag2.is_render && !rst_in;
   assign render_now = tag2.valid && tag2.is_render && !rst_in;

   always_comb begin
      resp_valid_out = '0;
      if (resp_now) resp_valid_out[tag2.id] = 1'b1;
   end

   assign resp_tile_out   = resp_now ? ram_tile_in : resp_tile_q;
   assign resp_solid_out  = SOLID_MASK[resp_tile_out];
   assign render_tile_out = render_now ? ram_tile_in : render_hold;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         first_cycle <= 1'b1;
         addr_q      <= '0;
         tag1        <= '0;
         tag2        <= '0;
         render_hold <= '0;
         resp_tile_q <= '0;
      end else begin
         if (render_slot) first_cycle <= 1'b0;
         addr_q      <= ram_addr_out;
         tag1        <= '{valid: ram_en_out, is_render: render_slot, id: gnt_id};
         tag2        <= tag1;
         render_hold <= render_tile_out;
         resp_tile_q <= resp_tile_out;
      end
   end
endmodule

// File: tb/tb_track_map_arbiter.sv
// Directed bench for track_map_arbiter with a 2-cycle-latency RAM model whose
// data is addr[3:0] ^ key.
module tb_track_map_arbiter;
   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [1:0]  req_in;
   logic [21:0] req_x_in;
   logic [21:0] req_y_in;
   logic [1:0]  gnt_out;
   logic [1:0]  resp_valid_out;
   logic [3:0]  resp_tile_out;
   logic        resp_solid_out;
   logic [7:0]  ram_addr_out;
   logic        ram_en_out;
   logic [3:0]  ram_tile_in;
   logic [3:0]  render_tile_out;

   logic [3:0]  key = 4'h0;
   logic [3:0]  d1;
   int          total = 0;
   int          bad   = 0;
   int          nxt;
   logic [1:0]  eg;

   track_map_arbiter #(.N_REQ(2), .SOLID_MASK(16'h0001)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .hcount_in       (hcount_in),
      .vcount_in       (vcount_in),
      .req_in          (req_in),
      .req_x_in        (req_x_in),
      .req_y_in        (req_y_in),
      .gnt_out         (gnt_out),
      .resp_valid_out  (resp_valid_out),
      .resp_tile_out   (resp_tile_out),
      .resp_solid_out  (resp_solid_out),
      .ram_addr_out    (ram_addr_out),
      .ram_en_out      (ram_en_out),
      .ram_tile_in     (ram_tile_in),
      .render_tile_out (render_tile_out)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      d1          <= ram_addr_out[3:0] ^ key;
      ram_tile_in <= d1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle, apply inputs just after the edge, then let them settle.
   task automatic go(input int h, input logic [1:0] r, input logic rs);
      @(posedge clk_in);
      #1;
      hcount_in = 11'(h);
      req_in    = r;
      rst_in    = rs;
      #1;
   endtask

   initial begin
      rst_in    = 1'b1;
      hcount_in = '0;
      vcount_in = 10'd37;
      req_in    = '0;
      req_x_in  = {11'd1000, 11'd300};
      req_y_in  = {11'd200,  11'd900};
      go(0, 2'b00, 1'b1);
      go(0, 2'b00, 1'b1);

      go(64, 2'b00, 1'b0);
      check("rst_gnt", gnt_out, 2'b00);
      check("rst_rv", resp_valid_out, 2'b00);
      check("rst_rt", resp_tile_out, 4'h0);
      check("rst_render", render_tile_out, 4'h0);
      check("rst_en", ram_en_out, 1'b1);
      check("rst_addr", ram_addr_out, 8'h12);

      for (int h = 65; h < 128; h++) begin
         go(h, 2'b00, 1'b0);
         check("sweep_en", ram_en_out, (h % 32 == 0) ? 1 : 0);
         check("sweep_render", render_tile_out, (h < 66) ? 0 : ((h < 98) ? 2 : 3));
         if (h == 96) check("sweep_addr96", ram_addr_out, 8'h13);
      end

      go(133, 2'b01, 1'b0);
      check("single_gnt", gnt_out, 2'b01);
      check("single_addr", ram_addr_out, 8'h72);
      check("single_en", ram_en_out, 1'b1);
      go(134, 2'b00, 1'b0);
      check("idle_en", ram_en_out, 1'b0);
      check("idle_addr_hold", ram_addr_out, 8'h72);
      check("idle_rv", resp_valid_out, 2'b00);
      go(135, 2'b00, 1'b0);
      check("single_rv", resp_valid_out, 2'b01);
      check("single_rt", resp_tile_out, 4'h2);
      check("single_solid", resp_solid_out, 1'b0);
      go(136, 2'b00, 1'b0);
      check("rv_pulse", resp_valid_out, 2'b00);
      check("rt_hold", resp_tile_out, 4'h2);

      nxt = 1;
      for (int h = 140; h < 166; h++) begin
         go(h, 2'b11, 1'b0);
         if (h % 32 == 0) begin
            check("both_slot_gnt", gnt_out, 2'b00);
            check("both_slot_addr", ram_addr_out, {4'h1, 4'(h >> 5)});
         end else begin
            eg = (nxt == 1) ? 2'b10 : 2'b01;
            check("both_gnt", gnt_out, eg);
            check("both_addr", ram_addr_out, (nxt == 1) ? 8'h17 : 8'h72);
            nxt = 1 - nxt;
         end
      end
      go(166, 2'b00, 1'b0);

      go(192, 2'b01, 1'b0);
      check("edge_gnt", gnt_out, 2'b00);
      check("edge_addr", ram_addr_out, 8'h16);
      check("edge_render", render_tile_out, 4'h5);
      go(193, 2'b01, 1'b0);
      check("edge_gnt_next", gnt_out, 2'b01);
      go(194, 2'b00, 1'b0);
      check("edge_render2", render_tile_out, 4'h6);
      go(195, 2'b00, 1'b0);
      check("edge_rv", resp_valid_out, 2'b01);
      check("edge_render3", render_tile_out, 4'h6);

      key = 4'h2;
      go(200, 2'b01, 1'b0);
      go(201, 2'b00, 1'b0);
      go(202, 2'b00, 1'b0);
      check("solid0_rt", resp_tile_out, 4'h0);
      check("solid0_s", resp_solid_out, 1'b1);
      key = 4'h3;
      go(204, 2'b01, 1'b0);
      go(205, 2'b00, 1'b0);
      go(206, 2'b00, 1'b0);
      check("solid1_rt", resp_tile_out, 4'h1);
      check("solid1_s", resp_solid_out, 1'b0);

      key = 4'h0;
      go(210, 2'b01, 1'b0);
      check("rstfly_gnt", gnt_out, 2'b01);
      go(211, 2'b00, 1'b1);
      go(212, 2'b00, 1'b0);
      check("rstfly_rv0", resp_valid_out, 2'b00);
      check("rstfly_render", render_tile_out, 4'h0);
      check("rstfly_first_en", ram_en_out, 1'b1);
      check("rstfly_first_addr", ram_addr_out, 8'h16);
      go(213, 2'b00, 1'b0);
      check("rstfly_rv1", resp_valid_out, 2'b00);
      check("rstfly_en1", ram_en_out, 1'b0);
      go(214, 2'b00, 1'b0);
      check("rstfly_rv2", resp_valid_out, 2'b00);
      check("rstfly_render2", render_tile_out, 4'h6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
